prbs22_checker: RTL and testbench
=================================

// Module: prbs22_checker
// PURPOSE
//  Serial PRBS checker; receive end of the 22-bit LFSR source (x^22+x^21+1,
//  new bit = x[21]^x[20], shifted into bit 0). Self-synchronises on the
//  incoming bit stream, then counts bit errors and locked bits for BER
//  measurement of the DSP datapath under test.
// PARAMETERS
//  N           22  LFSR length; taps fixed at N-1 and N-2
//  LOCK_CNT    32  consecutive correct predictions required to lock
//  WINDOW      64  valid-bit window for loss-of-lock detection
//  UNLOCK_ERRS 8   errors within one WINDOW that force loss of lock
//  CNT_W       32  width of err_count / bit_count
// PORTS
//  clk        in   1      system clock, rising edge
//  reset_n    in   1      asynchronous reset, active low
//  clear      in   1      sync clear of err_count/bit_count; state untouched
//  din_valid  in   1      din qualifier; nothing advances when low
//  din        in   1      received bit (source LFSR bit 0 each cycle)
//  locked     out  1      1 = state LOCKED
//  err_pulse  out  1      1-cycle pulse per detected bit error
//  err_count  out  CNT_W  errors while locked, saturating at all-ones
//  bit_count  out  CNT_W  valid bits checked while locked, saturating
// BEHAVIOUR
//  Reset (async assert, sync release): sr=0, fill=0, match=0, win=0,
//   werr=0, state HUNT; all outputs 0. Reset mid-stream: outputs 0 at once.
//  pred = sr[N-1]^sr[N-2]; all state advances only on din_valid=1.
//  All outputs registered: effect visible the cycle after the sampled bit.
//  HUNT: sr<={sr[N-2:0],din}; fill++; after N-th bit -> LOCKING, match=0.
//  LOCKING: compare din vs pred, sr<={sr,din} (re-seed from line).
//   match: match++; reaching LOCK_CNT -> LOCKED, win=0, werr=0.
//   mismatch or sr==0: match=0, stay LOCKING (all-zero stream never locks).
//  LOCKED: sr<={sr,pred} (flywheel; one flipped bit = exactly one error).
//   bit_count++ per valid bit; mismatch -> err_pulse=1, err_count++,
//   werr++; werr reaching UNLOCK_ERRS -> HUNT, fill=0 (counters held).
//   win++ per valid bit; on WINDOW-th bit win=0, werr=(this bit err?1:0),
//   unless the same bit unlocks (unlock wins).
//  Counters saturate at {CNT_W{1'b1}}; no wrap.
//  clear=1: err_count=0, bit_count=0 that cycle; clear beats a coincident
//   increment; err_pulse still fires for a coincident error.
//  err_pulse is 0 in HUNT/LOCKING and whenever din_valid=0.
//  Source restart (reload) while locked appears as errors; checker unlocks
//   via the window rule and relocks on its own.
// TESTING
//  1 Source reset, load, free-run; din=out[0], valid=1 -> locked=1 exactly
//    after 54th valid bit (N+LOCK_CNT), err_count=0, bit_count=+1/bit.
//  2 Locked; invert one bit -> one err_pulse, err_count=1, locked stays 1,
//    next 1000 bits no further errors.
//  3 Locked; invert 8 bits within 64 -> locked=0 after the 8th, err_count=8;
//    clean stream resumes -> relock 54 bits later, err_count still 8.
//  4 din constant 0 for 500 bits -> locked stays 0, err_pulse never high;
//    constant 1 likewise never locks (pred of all-ones = 0).
//  5 Case 1 with din_valid random 50% duty -> lock after 54 valid bits;
//    assert reset_n low mid-stream -> all outputs 0 same cycle, HUNT after.
//  6 clear coincident with injected error -> err_count=0, err_pulse=1;
//    preload counts near all-ones (CNT_W=4) -> saturate at 15, no wrap.

Source files
------------

// File: rtl/prbs22_checker.sv
// Self-synchronising serial PRBS checker for x^N+x^(N-1)+1 (default PRBS-22).
// Hunts for seed, verifies LOCK_CNT predictions, then flywheels and counts errors.
module prbs22_checker #(
  parameter int unsigned N           = 22,
  parameter int unsigned LOCK_CNT    = 32,
  parameter int unsigned WINDOW      = 64,
  parameter int unsigned UNLOCK_ERRS = 8,
  parameter int unsigned CNT_W       = 32
) (
  input  logic             clk_i,
  input  logic             rst_ni,
  input  logic             clear_i,
  input  logic             din_valid_i,
  input  logic             din_i,
  output logic             locked_o,
  output logic             err_pulse_o,
  output logic [CNT_W-1:0] err_count_o,
  output logic [CNT_W-1:0] bit_count_o
);

  localparam int unsigned FillW  = $clog2(N + 1);
  localparam int unsigned MatchW = $clog2(LOCK_CNT + 1);
  localparam int unsigned WinW   = $clog2(WINDOW + 1);
  localparam int unsigned WerrW  = $clog2(UNLOCK_ERRS + 1);
  localparam logic [CNT_W-1:0] CntMax = '1;

  typedef enum logic [1:0] {StHunt, StLocking, StLocked} state_e;

  state_e             state_q;
  logic [N-1:0]       sr_q;
  logic [FillW-1:0]   fill_q;
  logic [MatchW-1:0]  match_q;
  logic [WinW-1:0]    win_q;
  logic [WerrW-1:0]   werr_q;
  logic               err_pulse_q;
  logic [CNT_W-1:0]   err_cnt_q;
  logic [CNT_W-1:0]   bit_cnt_q;

  logic pred;
  logic mismatch;

  assign pred     = sr_q[N-1] ^ sr_q[N-2];
  assign mismatch = din_i ^ pred;

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q     <= StHunt;
      sr_q        <= '0;
      fill_q      <= '0;
      match_q     <= '0;
      win_q       <= '0;
      werr_q      <= '0;
      err_pulse_q <= 1'b0;
      err_cnt_q   <= '0;
      bit_cnt_q   <= '0;
    end else begin
      err_pulse_q <= 1'b0;
      if (din_valid_i) begin
        unique case (state_q)
          StHunt: begin
            sr_q   <= {sr_q[N-2:0], din_i};
            fill_q <= fill_q + 1'b1;
            if (fill_q == FillW'(N - 1)) begin
              state_q <= StLocking;
              match_q <= '0;
            end
          end
          StLocking: begin
            sr_q <= {sr_q[N-2:0], din_i};
            // An all-zero register predicts zeros forever, so it must never earn lock.
            if (mismatch || (sr_q == '0)) begin
              match_q <= '0;
            end else if (match_q == MatchW'(LOCK_CNT - 1)) begin
              state_q <= StLocked;
              match_q <= '0;
              win_q   <= '0;
              werr_q  <= '0;
            end else begin
              match_q <= match_q + 1'b1;
            end
          end
          StLocked: begin
            // Flywheel on the prediction so a flipped line bit costs exactly one error.
            sr_q <= {sr_q[N-2:0], pred};
            if (bit_cnt_q != CntMax) bit_cnt_q <= bit_cnt_q + 1'b1;
            if (mismatch) begin
              err_pulse_q <= 1'b1;
              if (err_cnt_q != CntMax) err_cnt_q <= err_cnt_q + 1'b1;
            end
            if (mismatch && (werr_q == WerrW'(UNLOCK_ERRS - 1))) begin
              state_q <= StHunt;
              fill_q  <= '0;
            end else if (win_q == WinW'(WINDOW - 1)) begin
              win_q  <= '0;
              werr_q <= WerrW'(mismatch);
            end else begin
              win_q  <= win_q + 1'b1;
              werr_q <= werr_q + WerrW'(mismatch);
            end
          end
          default: state_q <= StHunt;
        endcase
      end
      if (clear_i) begin
        err_cnt_q <= '0;
        bit_cnt_q <= '0;
      end
    end
  end

  assign locked_o    = (state_q == StLocked);
  assign err_pulse_o = err_pulse_q;
  assign err_count_o = err_cnt_q;
  assign bit_count_o = bit_cnt_q;

endmodule

// File: tb/tb_prbs22_checker.sv
// Bench for prbs22_checker: a 32-bit and a 4-bit counter instance share one stimulus
// stream; expectations come from directed rules and a queue-based reference model.
module tb_prbs22_checker;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        clear = 1'b0;
  logic        din_valid = 1'b0;
  logic        din = 1'b0;
  logic        locked, err_pulse, locked4, err_pulse4;
  logic [31:0] err_count, bit_count;
  logic [3:0]  err_count4, bit_count4;

  int tests = 0;
  int fails = 0;

  logic [21:0] src;

  // Reference model: history of the last 22 reference bits, oldest first.
  bit     ref_q[$];
  int     m_state;  // 0 hunt, 1 locking, 2 locked
  int     m_fill, m_match, m_win, m_werr;
  longint m_errs, m_bits;
  bit     m_pulse;

  always #5 clk = ~clk;

  prbs22_checker #(.CNT_W(32)) dut (
    .clk_i(clk), .rst_ni(rst_n), .clear_i(clear), .din_valid_i(din_valid), .din_i(din),
    .locked_o(locked), .err_pulse_o(err_pulse), .err_count_o(err_count),
    .bit_count_o(bit_count)
  );

  prbs22_checker #(.CNT_W(4)) dut4 (
    .clk_i(clk), .rst_ni(rst_n), .clear_i(clear), .din_valid_i(din_valid), .din_i(din),
    .locked_o(locked4), .err_pulse_o(err_pulse4), .err_count_o(err_count4),
    .bit_count_o(bit_count4)
  );

  function automatic longint sat(input longint v, input int w);
    longint mx;
    mx = (longint'(1) << w) - 1;
    return (v > mx) ? mx : v;
  endfunction

  task automatic model_reset();
    ref_q = {};
    repeat (22) ref_q.push_back(1'b0);
    m_state = 0; m_fill = 0; m_match = 0; m_win = 0; m_werr = 0;
    m_errs = 0; m_bits = 0; m_pulse = 1'b0;
  endtask

  task automatic model_step(input bit v, input bit d, input bit clr);
    bit p, e, any1;
    m_pulse = 1'b0;
    if (v) begin
      p = ref_q[0] ^ ref_q[1];
      any1 = 1'b0;
      foreach (ref_q[i]) any1 |= ref_q[i];
      case (m_state)
        0: begin
          ref_q.push_back(d);
          m_fill++;
          if (m_fill == 22) begin m_state = 1; m_match = 0; end
        end
        1: begin
          ref_q.push_back(d);
          if (d == p && any1) begin
            m_match++;
            if (m_match == 32) begin m_state = 2; m_win = 0; m_werr = 0; end
          end else m_match = 0;
        end
        default: begin
          e = (d != p);
          ref_q.push_back(p);
          m_bits++;
          if (e) begin m_pulse = 1'b1; m_errs++; m_werr++; end
          if (m_werr == 8) begin
            m_state = 0; m_fill = 0;
          end else begin
            m_win++;
            if (m_win == 64) begin m_win = 0; m_werr = e ? 1 : 0; end
          end
        end
      endcase
      void'(ref_q.pop_front());
    end
    if (clr) begin m_errs = 0; m_bits = 0; end
  endtask

  task automatic cycle(input bit v, input bit d, input bit clr);
    din_valid = v; din = d; clear = clr;
    @(posedge clk); #1;
    model_step(v, d, clr);
  endtask

  task automatic src_cycle(input bit v, input bit flip, input bit clr);
    bit d;
    d = v ? (src[0] ^ flip) : 1'($urandom);
    cycle(v, d, clr);
    if (v) src = {src[20:0], src[21] ^ src[20]};
  endtask

  task automatic seed_src();
    src = 22'($urandom);
    if (src == '0) src = 22'h1;
  endtask

  task automatic do_reset();
    rst_n = 1'b0; din_valid = 1'b0; clear = 1'b0;
    @(posedge clk); #1;
    rst_n = 1'b1;
    model_reset();
  endtask

  task automatic test_reset();
    model_reset();
    repeat (2) @(posedge clk);
    #1;
    tests++;
    if (locked !== 1'b0 || err_pulse !== 1'b0 || err_count !== 32'd0 || bit_count !== 32'd0) begin
      fails++;
      $display("FAIL reset_outputs: got locked=%b pulse=%b err=%0d bits=%0d, need all 0",
               locked, err_pulse, err_count, bit_count);
    end
    rst_n = 1'b1;
    repeat (3) cycle(1'b0, 1'b1, 1'b0);
    tests++;
    if (locked !== 1'b0 || err_count4 !== 4'd0 || bit_count4 !== 4'd0) begin
      fails++;
      $display("FAIL reset_idle: got locked=%b err4=%0d bits4=%0d, need 0", locked, err_count4,
               bit_count4);
    end
  endtask

  task automatic test_lock();
    seed_src();
    for (int i = 1; i <= 54; i++) begin
      src_cycle(1'b1, 1'b0, 1'b0);
      tests++;
      if (locked !== (i >= 54) || err_pulse !== 1'b0) begin
        fails++;
        $display("FAIL lock_timing bit %0d: got locked=%b pulse=%b, need locked=%b pulse=0",
                 i, locked, err_pulse, (i >= 54));
      end
    end
    tests++;
    if (err_count !== 32'd0 || bit_count !== 32'd0) begin
      fails++;
      $display("FAIL lock_counts: got err=%0d bits=%0d, need 0 0", err_count, bit_count);
    end
    for (int i = 1; i <= 10; i++) begin
      src_cycle(1'b1, 1'b0, 1'b0);
      tests++;
      if (bit_count !== 32'(i) || err_count !== 32'd0) begin
        fails++;
        $display("FAIL bit_count_step: got bits=%0d err=%0d, need bits=%0d err=0",
                 bit_count, err_count, i);
      end
    end
  endtask

  task automatic test_single_error();
    src_cycle(1'b1, 1'b0, 1'b1);
    src_cycle(1'b1, 1'b1, 1'b0);
    tests++;
    if (err_pulse !== 1'b1 || err_count !== 32'd1 || locked !== 1'b1) begin
      fails++;
      $display("FAIL single_error: got pulse=%b err=%0d locked=%b, need 1 1 1",
               err_pulse, err_count, locked);
    end
    for (int i = 0; i < 1000; i++) begin
      src_cycle(1'b1, 1'b0, 1'b0);
      if (err_pulse !== 1'b0 || locked !== 1'b1) begin
        tests++; fails++;
        $display("FAIL after_single bit %0d: got pulse=%b locked=%b, need 0 1", i, err_pulse,
                 locked);
      end
    end
    tests++;
    if (err_count !== 32'd1) begin
      fails++;
      $display("FAIL after_single_count: got err=%0d, need 1", err_count);
    end
  endtask

  task automatic test_unlock_relock();
    int guard;
    src_cycle(1'b1, 1'b0, 1'b1);
    guard = 0;
    while (m_win != 0 && guard < 64) begin
      src_cycle(1'b1, 1'b0, 1'b0);
      guard++;
    end
    tests++;
    if (m_win != 0) begin
      fails++;
      $display("FAIL window_align: window position %0d after %0d bits, need 0", m_win, guard);
    end
    for (int i = 0; i <= 21; i++) begin
      src_cycle(1'b1, (i % 3) == 0, 1'b0);
      if ((i % 3) == 0) begin
        tests++;
        if (locked !== (i != 21) || err_count !== 32'(i / 3 + 1) || err_pulse !== 1'b1) begin
          fails++;
          $display("FAIL burst_err %0d: got locked=%b err=%0d pulse=%b, need %b %0d 1",
                   i / 3 + 1, locked, err_count, err_pulse, (i != 21), i / 3 + 1);
        end
      end
    end
    for (int i = 1; i <= 54; i++) begin
      src_cycle(1'b1, 1'b0, 1'b0);
      tests++;
      if (locked !== (i >= 54) || err_count !== 32'd8 || err_pulse !== 1'b0) begin
        fails++;
        $display("FAIL relock bit %0d: got locked=%b err=%0d pulse=%b, need %b 8 0",
                 i, locked, err_count, err_pulse, (i >= 54));
      end
    end
  endtask

  task automatic test_constant();
    for (int k = 0; k < 2; k++) begin
      do_reset();
      for (int i = 0; i < 500; i++) begin
        cycle(1'b1, 1'(k), 1'b0);
        if (locked !== 1'b0 || err_pulse !== 1'b0) begin
          tests++; fails++;
          $display("FAIL constant_%0d bit %0d: got locked=%b pulse=%b, need 0 0", k, i, locked,
                   err_pulse);
        end
      end
      tests++;
      if (err_count !== 32'd0 || bit_count !== 32'd0) begin
        fails++;
        $display("FAIL constant_%0d_counts: got err=%0d bits=%0d, need 0 0", k, err_count,
                 bit_count);
      end
    end
  endtask

  task automatic test_random_valid();
    int nvalid;
    bit v;
    for (int pass = 0; pass < 2; pass++) begin
      if (pass == 0) begin do_reset(); seed_src(); end
      nvalid = 0;
      for (int c = 0; c < 1000 && nvalid < 60; c++) begin
        v = 1'($urandom);
        src_cycle(v, 1'b0, 1'b0);
        if (v) nvalid++;
        tests++;
        if (locked !== (nvalid >= 54) || err_pulse !== 1'b0) begin
          fails++;
          $display("FAIL gapped_lock pass %0d valid %0d: got locked=%b pulse=%b, need %b 0",
                   pass, nvalid, locked, err_pulse, (nvalid >= 54));
        end
      end
      tests++;
      if (nvalid < 60) begin
        fails++;
        $display("FAIL gapped_budget: got %0d valid bits, need 60", nvalid);
      end
      if (pass == 0) begin
        src_cycle(1'b1, 1'b1, 1'b0);
        #2 rst_n = 1'b0;
        #1;
        tests++;
        if (locked !== 1'b0 || err_pulse !== 1'b0 || err_count !== 32'd0 ||
            bit_count !== 32'd0) begin
          fails++;
          $display("FAIL async_reset: got locked=%b pulse=%b err=%0d bits=%0d, need all 0",
                   locked, err_pulse, err_count, bit_count);
        end
        @(posedge clk); #1;
        rst_n = 1'b1;
        model_reset();
      end
    end
  endtask

  task automatic test_clear_sat();
    do_reset();
    seed_src();
    repeat (54) src_cycle(1'b1, 1'b0, 1'b0);
    src_cycle(1'b1, 1'b1, 1'b1);
    tests++;
    if (err_pulse !== 1'b1 || err_count !== 32'd0 || err_count4 !== 4'd0 ||
        bit_count !== 32'd0) begin
      fails++;
      $display("FAIL clear_vs_error: got pulse=%b err=%0d err4=%0d bits=%0d, need 1 0 0 0",
               err_pulse, err_count, err_count4, bit_count);
    end
    for (int k = 1; k <= 20; k++) begin
      src_cycle(1'b1, 1'b1, 1'b0);
      repeat (31) src_cycle(1'b1, 1'b0, 1'b0);
      tests++;
      if (err_count4 !== 4'(sat(k, 4)) || err_count !== 32'(k)) begin
        fails++;
        $display("FAIL saturate_err %0d: got err4=%0d err=%0d, need %0d %0d", k, err_count4,
                 err_count, sat(k, 4), k);
      end
    end
    tests++;
    if (bit_count4 !== 4'd15 || bit_count !== 32'd640 || locked !== 1'b1) begin
      fails++;
      $display("FAIL saturate_bits: got bits4=%0d bits=%0d locked=%b, need 15 640 1",
               bit_count4, bit_count, locked);
    end
  endtask

  task automatic test_random_model();
    bit v, f, c;
    do_reset();
    seed_src();
    for (int i = 0; i < 3000; i++) begin
      v = ($urandom % 4) != 0;
      f = ($urandom % 50) == 0;
      c = ($urandom % 200) == 0;
      if (($urandom % 1500) == 0) seed_src();
      src_cycle(v, f, c);
      tests++;
      if (locked !== (m_state == 2) || err_pulse !== m_pulse ||
          err_count !== 32'(sat(m_errs, 32)) || bit_count !== 32'(sat(m_bits, 32)) ||
          err_count4 !== 4'(sat(m_errs, 4)) || bit_count4 !== 4'(sat(m_bits, 4))) begin
        fails++;
        $display("FAIL model cyc %0d: got lk=%b p=%b e=%0d b=%0d e4=%0d b4=%0d, need %b %b %0d %0d %0d %0d",
                 i, locked, err_pulse, err_count, bit_count, err_count4, bit_count4,
                 (m_state == 2), m_pulse, sat(m_errs, 32), sat(m_bits, 32), sat(m_errs, 4),
                 sat(m_bits, 4));
      end
    end
  endtask

  initial begin
    test_reset();
    test_lock();
    test_single_error();
    test_unlock_relock();
    test_constant();
    test_random_valid();
    test_clear_sat();
    test_random_model();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
